// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage buffers: ID/EX payload layout,
// control-bit indices and per-stage payload widths. The optional statistics
// counters of pipe_stage_buf are enabled with the PIPE_STAGE_STATS_EN macro.
package pipe_pkg;

  // Basic field widths
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned CTRL_W  = 7;

  // Control-bit indices inside the CTRL_W-bit control field
  localparam int unsigned CTRL_REG_DST   = 0;
  localparam int unsigned CTRL_ALU_SRC   = 1;
  localparam int unsigned CTRL_MEM_TO_REG = 2;
  localparam int unsigned CTRL_REG_WRITE = 3;
  localparam int unsigned CTRL_MEM_READ  = 4;
  localparam int unsigned CTRL_MEM_WRITE = 5;
  localparam int unsigned CTRL_BRANCH    = 6;

  // Same control bits as a packed struct; bit order matches the indices above
  typedef struct packed {
    logic branch;
    logic memWrite;
    logic memRead;
    logic regWrite;
    logic memtoReg;
    logic aluSrc;
    logic regDst;
  } ctrlBits_t;

  // ID/EX payload layout, LSB first:
  //   ctrl(7) | aluOp(3) | rt(5) | reserved(3) | nextPC | imm | readData2 | readData1
  // rd and funct are not carried separately: for R-type instructions they sit
  // in the sign-extended immediate at imm[15:11] and imm[5:0].
  localparam int unsigned ID_EX_RSVD_W       = 3;
  localparam int unsigned ID_EX_CTRL_LSB     = 0;
  localparam int unsigned ID_EX_ALUOP_LSB    = ID_EX_CTRL_LSB + CTRL_W;
  localparam int unsigned ID_EX_RT_LSB       = ID_EX_ALUOP_LSB + ALUOP_W;
  localparam int unsigned ID_EX_RSVD_LSB     = ID_EX_RT_LSB + REG_W;
  localparam int unsigned ID_EX_FIELD_W      = ID_EX_RSVD_LSB + ID_EX_RSVD_W;
  localparam int unsigned ID_EX_NEXT_PC_LSB  = ID_EX_FIELD_W;
  localparam int unsigned ID_EX_IMM_LSB      = ID_EX_NEXT_PC_LSB + WORD_W;
  localparam int unsigned ID_EX_READ_DATA2_LSB = ID_EX_IMM_LSB + WORD_W;
  localparam int unsigned ID_EX_READ_DATA1_LSB = ID_EX_READ_DATA2_LSB + WORD_W;

  // Sub-fields recovered from the immediate in EX
  localparam int unsigned IMM_RD_LSB    = 11;
  localparam int unsigned IMM_FUNCT_LSB = 0;

  // Payload widths per stage
  localparam int unsigned IF_ID_PAYLOAD_W  = 2 * WORD_W;                        // instr + nextPC
  localparam int unsigned ID_EX_PAYLOAD_W  = ID_EX_READ_DATA1_LSB + WORD_W;     // 146
  localparam int unsigned EX_MEM_PAYLOAD_W = 3 * WORD_W + 1 + REG_W + 5;        // alu/wdata/target, zero, dest, ctrl
  localparam int unsigned MEM_WB_PAYLOAD_W = 2 * WORD_W + REG_W + 2;            // rdata/alu, dest, ctrl

  // Pack the ID/EX fields into one opaque payload vector
  function automatic logic [ID_EX_PAYLOAD_W-1:0] packIdEx(
    input logic [WORD_W-1:0]  readData1,
    input logic [WORD_W-1:0]  readData2,
    input logic [WORD_W-1:0]  imm,
    input logic [WORD_W-1:0]  nextPc,
    input ctrlBits_t          ctrl,
    input logic [ALUOP_W-1:0] aluOp,
    input logic [REG_W-1:0]   rt
  );
    return {readData1, readData2, imm, nextPc, {ID_EX_RSVD_W{1'b0}}, rt, aluOp, ctrl};
  endfunction

  // True when v is a non-zero power of two
  function automatic bit isPow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// DEPTH x PAYLOAD_W register array for pipe_stage_buf: synchronous write,
// asynchronous read, synchronous clear of every entry on rst.
module pipe_stage_mem
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = ID_EX_PAYLOAD_W,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned PTR_W     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wrEn,
  input  logic [PTR_W-1:0]     wrAddr,
  input  logic [PAYLOAD_W-1:0] wrData,
  input  logic [PTR_W-1:0]     rdAddr,
  output logic [PAYLOAD_W-1:0] rdData
);

  logic [PAYLOAD_W-1:0] mem [DEPTH];

  // Storage: zero every entry on reset, otherwise write one entry when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Head entry is read combinationally from the read pointer
  assign rdData = mem[rdAddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: a DEPTH-entry circular buffer carrying
// one opaque payload per instruction between two pipeline stages.
// Optional build macro: PIPE_STAGE_STATS_EN adds stall_cnt / bubble_cnt.
//
// Handshake: a transfer happens on a rising edge only when valid and ready
// are both high in that cycle, hit is high and flush is low. in_ready and
// out_valid depend only on the registered occupancy, never on the other
// side's inputs, so there is no combinational path from in_* to out_*.
// A producer may drop or change its offer after a flush.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 146,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hit,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CNT_W-1:0]     occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          bubble_cnt
`endif
);

  // DEPTH is a power of two, so pointers of log2(DEPTH) bits wrap naturally
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit DEPTH_OK = isPow2(DEPTH) && (DEPTH >= 2);

  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  // Handshake qualification; flush cancels any offer in the same cycle
  assign in_ready  = DEPTH_OK && (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign doPush    = in_valid & in_ready & hit & ~flush;
  assign doPop     = out_valid & out_ready & hit & ~flush;
  assign occupancy = count;

  // Pointer and occupancy state: rst > flush > hit gating > push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= wrPtr;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  pipe_stage_mem #(
    .PAYLOAD_W (PAYLOAD_W),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (doPush),
    .wrAddr (wrPtr),
    .wrData (in_data),
    .rdAddr (rdPtr),
    .rdData (out_data)
  );

`ifdef PIPE_STAGE_STATS_EN
  logic stallEvt;
  logic bubbleEvt;

  // Producer blocked by a full buffer or by a cache-miss freeze
  assign stallEvt  = in_valid & (~in_ready | ~hit);
  // Consumer ready but nothing to hand over while the pipeline is running
  assign bubbleEvt = out_ready & ~out_valid & hit;

  // Saturating event counters, cleared by rst only
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stallEvt && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (bubbleEvt && (bubble_cnt != 16'hFFFF)) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
    end
  end
`else
  // Statistics disabled: no counter ports and no counter logic.
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (DEPTH = 2, 146-bit payload).
module tb_pipe_stage_buf;
  localparam int PW    = 146;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          hit;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic [CNT_W-1:0] occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q[$];

  // Clock and DUT
  always #5 clk = ~clk;

  pipe_stage_buf #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .hit       (hit),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Status word {occupancy, out_valid, in_ready}
  function automatic logic [3:0] status();
    return {occupancy, out_valid, in_ready};
  endfunction

  task automatic test_reset();
    rst = 1'b1; hit = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    total++;
    if (status() !== 4'b00_0_1) begin
      bad++; $display("FAIL reset_status got=%b want=0001", status());
    end
    total++;
    if (out_data !== '0) begin
      bad++; $display("FAIL reset_data got=%h want=0", out_data);
    end
`ifdef PIPE_STAGE_STATS_EN
    total++;
    if ({stall_cnt, bubble_cnt} !== 32'h0) begin
      bad++; $display("FAIL reset_stats got=%h/%h want=0/0", stall_cnt, bubble_cnt);
    end
`endif
    step();
    total++;
    if (status() !== 4'b00_0_1) begin
      bad++; $display("FAIL reset_idle got=%b want=0001", status());
    end
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_data = PW'(32'hA5A5); out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    total++;
    if (status() !== 4'b01_1_1 || out_data !== PW'(32'hA5A5)) begin
      bad++; $display("FAIL single_push got=%b/%h want=0111/a5a5", status(), out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    // Empty again; out_data shows the never-written (cleared) entry 1
    total++;
    if (status() !== 4'b00_0_1 || out_data !== '0) begin
      bad++; $display("FAIL single_pop got=%b/%h want=0001/0", status(), out_data);
    end
  endtask

  task automatic test_full();
    in_valid = 1'b1; in_data = PW'(1); out_ready = 1'b0;
    step();
    in_data = PW'(2);
    step();
    total++;
    if (status() !== 4'b10_1_0 || out_data !== PW'(1)) begin
      bad++; $display("FAIL full_reached got=%b/%h want=1010/1", status(), out_data);
    end
    in_data = PW'(3);
    step();
    total++;
    if (status() !== 4'b10_1_0 || out_data !== PW'(1)) begin
      bad++; $display("FAIL full_no_push got=%b/%h want=1010/1", status(), out_data);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (status() !== 4'b01_1_1 || out_data !== PW'(2)) begin
      bad++; $display("FAIL full_pop1 got=%b/%h want=0111/2", status(), out_data);
    end
    step();
    total++;
    if (status() !== 4'b01_1_1 || out_data !== PW'(3)) begin
      bad++; $display("FAIL full_push3 got=%b/%h want=0111/3", status(), out_data);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    total++;
    if (status() !== 4'b00_0_1 || out_data !== PW'(2)) begin
      bad++; $display("FAIL full_drain got=%b/%h want=0001/2", status(), out_data);
    end
  endtask

  task automatic test_hit();
    in_valid = 1'b1; in_data = PW'(8'h55); out_ready = 1'b0;
    step();
    hit = 1'b0; in_data = PW'(8'h66); out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (status() !== 4'b01_1_1 || out_data !== PW'(8'h55)) begin
        bad++; $display("FAIL hit_freeze%0d got=%b/%h want=0111/55", c, status(), out_data);
      end
    end
    hit = 1'b1;
    step();
    total++;
    if (status() !== 4'b01_1_1 || out_data !== PW'(8'h66)) begin
      bad++; $display("FAIL hit_resume got=%b/%h want=0111/66", status(), out_data);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    total++;
    if (status() !== 4'b00_0_1 || out_data !== PW'(8'h55)) begin
      bad++; $display("FAIL hit_drain got=%b/%h want=0001/55", status(), out_data);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = PW'(8'h10);
    step();
    in_data = PW'(8'h11);
    step();
    // Flush at full while frozen: flush wins over hit
    hit = 1'b0; flush = 1'b1; in_data = PW'(8'h7);
    step();
    hit = 1'b1; flush = 1'b0; in_valid = 1'b0;
    total++;
    if (status() !== 4'b00_0_1 || out_data !== PW'(8'h10)) begin
      bad++; $display("FAIL flush_full got=%b/%h want=0001/10", status(), out_data);
    end
    in_valid = 1'b1; in_data = PW'(8'h20);
    step();
    total++;
    if (status() !== 4'b01_1_1 || out_data !== PW'(8'h20)) begin
      bad++; $display("FAIL flush_refill got=%b/%h want=0111/20", status(), out_data);
    end
    // Flush with a pushable offer: 0x7 must not land in entry 1 (holds 0x11)
    flush = 1'b1; in_data = PW'(8'h7); out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (status() !== 4'b00_0_1 || out_data !== PW'(8'h11)) begin
      bad++; $display("FAIL flush_drop got=%b/%h want=0001/11", status(), out_data);
    end
    in_valid = 1'b1; in_data = PW'(8'h30);
    step();
    in_valid = 1'b0;
    total++;
    if (status() !== 4'b01_1_1 || out_data !== PW'(8'h30)) begin
      bad++; $display("FAIL flush_after got=%b/%h want=0111/30", status(), out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] exp;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall0;
    logic [15:0] bubble0;
    stall0  = stall_cnt;
    bubble0 = bubble_cnt;
`endif
    exp_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = PW'(k);
      exp_q.push_back(PW'(k));
      step();
      exp = exp_q.pop_front();
      total++;
      if (status() !== 4'b01_1_1 || out_data !== exp) begin
        bad++; $display("FAIL stream%0d got=%b/%h want=0111/%h", k, status(), out_data, exp);
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    total++;
    if (status() !== 4'b00_0_1 || exp_q.size() != 0) begin
      bad++; $display("FAIL stream_end got=%b q=%0d want=0001 q=0", status(), exp_q.size());
    end
`ifdef PIPE_STAGE_STATS_EN
    total++;
    if ((stall_cnt - stall0) !== 16'd0 || (bubble_cnt - bubble0) !== 16'd1) begin
      bad++; $display("FAIL stream_stats got=%0d/%0d want=0/1", stall_cnt - stall0, bubble_cnt - bubble0);
    end
`endif
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; in_data = PW'(8'h99);
    step();
    in_valid = 1'b0;
    total++;
    if (status() !== 4'b01_1_1 || out_data !== PW'(8'h99)) begin
      bad++; $display("FAIL midrst_pre got=%b/%h want=0111/99", status(), out_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (status() !== 4'b00_0_1 || out_data !== '0) begin
      bad++; $display("FAIL midrst_post got=%b/%h want=0001/0", status(), out_data);
    end
`ifdef PIPE_STAGE_STATS_EN
    total++;
    if ({stall_cnt, bubble_cnt} !== 32'h0) begin
      bad++; $display("FAIL midrst_stats got=%h/%h want=0/0", stall_cnt, bubble_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full();
    test_hit();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
